dual_issue_stage: RTL and testbench

//  Decode/issue stage downstream of the two-wide instruction queue. Each cycle it

---
 rtl/dual_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_dual_issue_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dual_issue_stage.sv
// Two-wide in-order decode/issue stage with a register scoreboard.
// Issues 0, 1 or 2 instructions per cycle from the queue head pair into two registered slots.
module dual_issue_stage #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_a,
    input  logic [31:0]      instr_b,
    output logic [1:0]       shift_count,
    output logic             iss0_valid,
    input  logic             iss0_ready,
    output logic [2:0]       iss0_op,
    output logic [4:0]       iss0_rd,
    output logic [4:0]       iss0_rs1,
    output logic [4:0]       iss0_rs2,
    output logic [31:0]      iss0_imm,
    output logic             iss1_valid,
    input  logic             iss1_ready,
    output logic [2:0]       iss1_op,
    output logic [4:0]       iss1_rd,
    output logic [4:0]       iss1_rs1,
    output logic [4:0]       iss1_rs2,
    output logic [31:0]      iss1_imm,
    input  logic             wb0_valid,
    input  logic [4:0]       wb0_rd,
    input  logic             wb1_valid,
    input  logic [4:0]       wb1_rd,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_ADD     = 3'd2;
    localparam logic [2:0] OP_MUL     = 3'd3;
    localparam logic [2:0] OP_ADDI    = 3'd4;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } pkt_t;

    function automatic pkt_t decode(input logic [31:0] ins);
        pkt_t d;
        d.op  = OP_ILLEGAL;
        d.rd  = '0;
        d.rs1 = '0;
        d.rs2 = '0;
        d.imm = '0;
        case (ins[6:0])
            7'b0000011, 7'b0010011: begin
                d.op  = (ins[6:0] == 7'b0000011) ? OP_LOAD : OP_ADDI;
                d.rd  = ins[11:7];
                d.rs1 = ins[19:15];
                d.rs2 = ins[24:20];
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0110011: begin
                if (ins[14:12] == 3'b000 &&
                    (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0000001)) begin
                    d.op  = ins[25] ? OP_MUL : OP_ADD;
                    d.rd  = ins[11:7];
                    d.rs1 = ins[19:15];
                    d.rs2 = ins[24:20];
                end
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic is_rtype(input pkt_t d);
        return (d.op == OP_ADD) || (d.op == OP_MUL);
    endfunction

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_next;

    pkt_t dec_a;
    pkt_t dec_b;
    pkt_t slot0;
    pkt_t slot1;

    logic slot0_free;
    logic slot1_free;
    logic hazard_a;
    logic hazard_b;
    logic pair_dep;
    logic issue_a;
    logic issue_b;

    assign dec_a = decode(instr_a);
    assign dec_b = decode(instr_b);

    assign slot0_free = !iss0_valid || iss0_ready;
    assign slot1_free = !iss1_valid || iss1_ready;

    // Hazards use only the registered scoreboard; a writeback this cycle frees the register next cycle
    assign hazard_a = busy[dec_a.rs1] | (is_rtype(dec_a) & busy[dec_a.rs2]) | busy[dec_a.rd];
    assign hazard_b = busy[dec_b.rs1] | (is_rtype(dec_b) & busy[dec_b.rs2]) | busy[dec_b.rd];

    assign pair_dep = (dec_a.rd != 5'd0) &&
                      ((dec_a.rd == dec_b.rs1) ||
                       (is_rtype(dec_b) && (dec_a.rd == dec_b.rs2)) ||
                       (dec_a.rd == dec_b.rd));

    assign issue_a     = !reset && slot0_free && !hazard_a;
    assign issue_b     = issue_a && slot1_free && !hazard_b && !pair_dep;
    assign shift_count = {1'b0, issue_a} + {1'b0, issue_b};

    // Set is applied after clear so an issue to a register being written back keeps it busy
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (wb0_valid) busy_clr[wb0_rd] = 1'b1;
        if (wb1_valid) busy_clr[wb1_rd] = 1'b1;
        if (issue_a)   busy_set[dec_a.rd] = 1'b1;
        if (issue_b)   busy_set[dec_b.rd] = 1'b1;
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            issued_cnt <= '0;
            iss0_valid <= 1'b0;
            iss1_valid <= 1'b0;
            slot0      <= '0;
            slot1      <= '0;
        end else begin
            busy       <= busy_next;
            issued_cnt <= issued_cnt + CNT_W'(shift_count);
            if (issue_a) begin
                slot0      <= dec_a;
                iss0_valid <= 1'b1;
            end else if (iss0_ready) begin
                iss0_valid <= 1'b0;
            end
            if (issue_b) begin
                slot1      <= dec_b;
                iss1_valid <= 1'b1;
            end else if (iss1_ready) begin
                iss1_valid <= 1'b0;
            end
        end
    end

    assign iss0_op  = slot0.op;
    assign iss0_rd  = slot0.rd;
    assign iss0_rs1 = slot0.rs1;
    assign iss0_rs2 = slot0.rs2;
    assign iss0_imm = slot0.imm;
    assign iss1_op  = slot1.op;
    assign iss1_rd  = slot1.rd;
    assign iss1_rs1 = slot1.rs1;
    assign iss1_rs2 = slot1.rs2;
    assign iss1_imm = slot1.imm;

endmodule

// File: tb/tb_dual_issue_stage.sv
// Directed bench for dual_issue_stage: expected slot packets are queued when driven
// and compared after the clock edge that loads them.
module tb_dual_issue_stage;

    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] ADDI = 3'd4;
    localparam logic [2:0] ILL  = 3'd7;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_a, instr_b;
    logic [1:0]  shift_count;
    logic        iss0_valid, iss0_ready, iss1_valid, iss1_ready;
    logic [2:0]  iss0_op, iss1_op;
    logic [4:0]  iss0_rd, iss0_rs1, iss0_rs2, iss1_rd, iss1_rs1, iss1_rs2;
    logic [31:0] iss0_imm, iss1_imm;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] issued_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_cnt = 0;
    pkt_t exp_q[$];
    pkt_t none;

    dual_issue_stage #(.NREG(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .instr_a(instr_a), .instr_b(instr_b), .shift_count(shift_count),
        .iss0_valid(iss0_valid), .iss0_ready(iss0_ready), .iss0_op(iss0_op),
        .iss0_rd(iss0_rd), .iss0_rs1(iss0_rs1), .iss0_rs2(iss0_rs2), .iss0_imm(iss0_imm),
        .iss1_valid(iss1_valid), .iss1_ready(iss1_ready), .iss1_op(iss1_op),
        .iss1_rd(iss1_rd), .iss1_rs1(iss1_rs1), .iss1_rs2(iss1_rs2), .iss1_imm(iss1_imm),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic pkt_t mk(input logic v, input logic [2:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        pkt_t p;
        p.valid = v; p.op = op; p.rd = rd; p.rs1 = rs1; p.rs2 = rs2; p.imm = imm;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic [31:0] b,
                                 input logic r0, input logic r1,
                                 input logic w0v, input logic [4:0] w0rd,
                                 input logic w1v, input logic [4:0] w1rd);
        reset = rst; instr_a = a; instr_b = b;
        iss0_ready = r0; iss1_ready = r1;
        wb0_valid = w0v; wb0_rd = w0rd; wb1_valid = w1v; wb1_rd = w1rd;
        #1;
    endtask

    task automatic checkSlots(input string tag);
        pkt_t e0, e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checkOutput({tag, ".v0"}, 32'(iss0_valid), 32'(e0.valid));
        checkOutput({tag, ".v1"}, 32'(iss1_valid), 32'(e1.valid));
        if (e0.valid) begin
            checkOutput({tag, ".op0"},  32'(iss0_op),  32'(e0.op));
            checkOutput({tag, ".rd0"},  32'(iss0_rd),  32'(e0.rd));
            checkOutput({tag, ".rs10"}, 32'(iss0_rs1), 32'(e0.rs1));
            checkOutput({tag, ".rs20"}, 32'(iss0_rs2), 32'(e0.rs2));
            checkOutput({tag, ".imm0"}, iss0_imm, e0.imm);
        end
        if (e1.valid) begin
            checkOutput({tag, ".op1"},  32'(iss1_op),  32'(e1.op));
            checkOutput({tag, ".rd1"},  32'(iss1_rd),  32'(e1.rd));
            checkOutput({tag, ".rs11"}, 32'(iss1_rs1), 32'(e1.rs1));
            checkOutput({tag, ".rs21"}, 32'(iss1_rs2), 32'(e1.rs2));
            checkOutput({tag, ".imm1"}, iss1_imm, e1.imm);
        end
    endtask

    // One clock: drive, check the combinational shift, queue expected slots, then check after the edge
    task automatic step(input string tag, input logic rst, input logic [31:0] a, input logic [31:0] b,
                        input logic r0, input logic r1,
                        input logic w0v, input logic [4:0] w0rd,
                        input logic w1v, input logic [4:0] w1rd,
                        input int exp_shift, input pkt_t e0, input pkt_t e1);
        applyStimulus(rst, a, b, r0, r1, w0v, w0rd, w1v, w1rd);
        checkOutput({tag, ".shift"}, 32'(shift_count), 32'(exp_shift));
        if (rst) exp_cnt = 0;
        else     exp_cnt += exp_shift;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        @(posedge clk);
        #1;
        checkSlots(tag);
        checkOutput({tag, ".cnt"}, issued_cnt, 32'(exp_cnt));
    endtask

    initial begin
        none = mk(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("T1.shift", 32'(shift_count), 32'd0);
        checkOutput("T1.v0", 32'(iss0_valid), 32'd0);
        checkOutput("T1.v1", 32'(iss1_valid), 32'd0);
        checkOutput("T1.cnt", issued_cnt, 32'd0);

        step("T2", 1'b0, 32'h00702383, 32'h00502283, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             2, mk(1'b1, LOAD, 5'd7, 5'd0, 5'd7, 32'd7), mk(1'b1, LOAD, 5'd5, 5'd0, 5'd5, 32'd5));

        step("T3stall", 1'b0, 32'h007280b3, 32'h005080b3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             0, none, none);
        step("T3wb", 1'b0, 32'h007280b3, 32'h005080b3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7,
             0, none, none);
        step("T3issue", 1'b0, 32'h007280b3, 32'h005080b3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             1, mk(1'b1, ADD, 5'd1, 5'd5, 5'd7, 32'd0), none);

        for (int i = 0; i < 5; i++)
            step("T4hold", 1'b0, 32'h00000013, 32'h00000013, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
                 0, mk(1'b1, ADD, 5'd1, 5'd5, 5'd7, 32'd0), none);
        step("T4refill", 1'b0, 32'h00000013, 32'h00000013, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             2, mk(1'b1, ADDI, 5'd0, 5'd0, 5'd0, 32'd0), mk(1'b1, ADDI, 5'd0, 5'd0, 5'd0, 32'd0));

        step("T5setwins", 1'b0, 32'h00100193, 32'hffffffff, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0,
             2, mk(1'b1, ADDI, 5'd3, 5'd0, 5'd1, 32'd1), mk(1'b1, ILL, 5'd0, 5'd0, 5'd0, 32'd0));
        step("T5busy3", 1'b0, 32'h00018233, 32'hffffffff, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             0, none, none);
        step("T5illegal", 1'b0, 32'hffffffff, 32'h00018233, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             1, mk(1'b1, ILL, 5'd0, 5'd0, 5'd0, 32'd0), none);

        step("T6fill", 1'b0, 32'hfff00113, 32'hfff00313, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             2, mk(1'b1, ADDI, 5'd2, 5'd0, 5'd31, 32'hffffffff),
             mk(1'b1, ADDI, 5'd6, 5'd0, 5'd31, 32'hffffffff));
        step("T6reset", 1'b1, 32'hffffffff, 32'hffffffff, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             0, none, none);
        checkOutput("T6.op0zero", 32'(iss0_op), 32'd0);
        checkOutput("T6.imm1zero", iss1_imm, 32'd0);
        step("T6mul", 1'b0, 32'h02728133, 32'h00018233, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             2, mk(1'b1, MUL, 5'd2, 5'd5, 5'd7, 32'd0), mk(1'b1, ADD, 5'd4, 5'd3, 5'd0, 32'd0));

        step("WAWpair", 1'b0, 32'h00500493, 32'h00600493, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,
             1, mk(1'b1, ADDI, 5'd9, 5'd0, 5'd5, 32'd5), none);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
